serial_ripple_subtractor: RTL and testbench

//  Bit-serial subtractor: computes DiffOut = InputA - InputB - InputBorrow (mod 2^WIDTH) one bit per clock.

---
 rtl/rca_pkg.sv | 13 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_ripple_subtractor.sv | 113 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple/serial arithmetic blocks.
// Holds the FSM state encoding and the default operand width.
package rca_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : rca_pkg

// File: rtl/full_subtractor.sv
// One-bit combinational subtractor cell: DiffOut = A - B - Bin, with borrow out.
module full_subtractor (
    input  logic InputA,
    input  logic InputB,
    input  logic InputBorrow,
    output logic DiffOut,
    output logic BorrowOut
);

    assign DiffOut   = InputA ^ InputB ^ InputBorrow;
    assign BorrowOut = (~InputA & InputB) | (~(InputA ^ InputB) & InputBorrow);

endmodule : full_subtractor

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: one full_subtractor cell iterated LSB-first over WIDTH clocks,
// wrapped in an IDLE/RUN/DONE handshake with registered, glitch-free result outputs.
module serial_ripple_subtractor
    import rca_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             InputBorrow,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] DiffOut,
    output logic             BorrowOut
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_out_q, diff_out_d;
    logic               borrow_out_q, borrow_out_d;

    logic               cell_diff;
    logic               cell_borrow;

    full_subtractor u_cell (
        .InputA      (a_q[0]),
        .InputB      (b_q[0]),
        .InputBorrow (br_q),
        .DiffOut     (cell_diff),
        .BorrowOut   (cell_borrow)
    );

    // NOTE: every _d starts from its _q so no path through the case leaves a latch.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        diff_d       = diff_q;
        br_d         = br_q;
        cnt_d        = cnt_q;
        diff_out_d   = diff_out_q;
        borrow_out_d = borrow_out_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    a_d     = InputA;
                    b_d     = InputB;
                    br_d    = InputBorrow;
                    diff_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                diff_d = {cell_diff, diff_q[WIDTH-1:1]};
                br_d   = cell_borrow;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the completed word and final borrow together.
                    state_d      = ST_DONE;
                    diff_out_d   = {cell_diff, diff_q[WIDTH-1:1]};
                    borrow_out_d = cell_borrow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            diff_out_q   <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            diff_q       <= diff_d;
            br_q         <= br_d;
            cnt_q        <= cnt_d;
            diff_out_q   <= diff_out_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign Busy      = (state_q == ST_RUN);
    assign Done      = (state_q == ST_DONE);
    assign DiffOut   = diff_out_q;
    assign BorrowOut = borrow_out_q;

endmodule : serial_ripple_subtractor

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor (WIDTH=4): latency, results, dropped
// requests, back-to-back operation and mid-run reset, with hand-computed expectations.
module tb_serial_ripple_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_borrow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;

    int checks = 0;
    int errors = 0;

    serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
        .Clock       (clk),
        .Reset       (reset),
        .Start       (start),
        .InputA      (in_a),
        .InputB      (in_b),
        .InputBorrow (in_borrow),
        .Busy        (busy),
        .Done        (done),
        .DiffOut     (diff_out),
        .BorrowOut   (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse Start for one clock; returns at the falling edge of the first RUN cycle.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        start     = 1'b1;
        in_a      = a;
        in_b      = b;
        in_borrow = bin;
        @(negedge clk);
        start     = 1'b0;
        in_a      = 4'h0;
        in_b      = 4'h0;
        in_borrow = 1'b0;
    endtask

    // Full transaction: Busy for exactly 4 cycles with the old result held, then one Done.
    task automatic run_and_check(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input logic [WIDTH-1:0] prev_diff,
                                 input logic [WIDTH-1:0] exp_diff, input logic exp_bo);
        start_op(a, b, bin);
        for (int i = 0; i < WIDTH; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_held"}, 32'(diff_out), 32'(prev_diff));
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff_out), 32'(exp_diff));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(exp_bo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_seen;

        reset     = 1'b1;
        start     = 1'b0;
        in_a      = 4'h0;
        in_b      = 4'h0;
        in_borrow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff_out), 32'd0);
        check("reset_borrow", 32'(borrow_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 9-3 = 6, no borrow
        run_and_check("t1", 4'd9, 4'd3, 1'b0, 4'h0, 4'h6, 1'b0);
        // 3-9 = -6 -> A, borrow
        run_and_check("t2", 4'd3, 4'd9, 1'b0, 4'h6, 4'hA, 1'b1);
        // 0-0-1 -> F, borrow; F-F -> 0, no borrow
        run_and_check("t3a", 4'h0, 4'h0, 1'b1, 4'hA, 4'hF, 1'b1);
        run_and_check("t3b", 4'hF, 4'hF, 1'b0, 4'hF, 4'h0, 1'b0);

        // Start during Busy with different operands is dropped.
        start_op(4'd9, 4'd3, 1'b0);
        check("t4_busy", 32'(busy), 32'd1);
        start = 1'b1; in_a = 4'd1; in_b = 4'd2;
        @(negedge clk);
        start = 1'b0; in_a = 4'd0; in_b = 4'd0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t4_done", 32'(done), 32'd1);
        check("t4_diff", 32'(diff_out), 32'h6);
        check("t4_borrow", 32'(borrow_out), 32'd0);

        // Back-to-back: Start held in the DONE cycle with 5-7.
        start = 1'b1; in_a = 4'd5; in_b = 4'd7; in_borrow = 1'b0;
        @(negedge clk);
        start = 1'b0; in_a = 4'd0; in_b = 4'd0;
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_nodone", 32'(done), 32'd0);
        check("t5_prior", 32'(diff_out), 32'h6);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("t5_done", 32'(done), 32'd1);
        check("t5_diff", 32'(diff_out), 32'hE);
        check("t5_borrow", 32'(borrow_out), 32'd1);
        @(negedge clk);
        check("t5_single", 32'(done), 32'd0);
        check("t4_dropped", 32'(busy), 32'd0);

        // Reset in the second RUN cycle aborts without a Done pulse.
        start_op(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        check("t6_running", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_diff", 32'(diff_out), 32'd0);
        check("t6_borrow", 32'(borrow_out), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("t6_no_done", 32'(done_seen), 32'd0);
        // Fresh start after reset: 7-2-1 = 4
        run_and_check("t6_fresh", 4'd7, 4'd2, 1'b1, 4'h0, 4'h4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_ripple_subtractor
